alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Mode/timekeeping controller for the alarm clock. Consumes the 1 Hz enable from clock_divider
//  and the user switches/button. Keeps time-of-day and alarm registers and sequences
//  run / set-time / set-alarm / ringing. Drives the display fields, the blink flag and the buzzer enable.
// PARAMETERS
//  RING_SECS    60   ticks RINGING lasts before auto-dismiss (>=1)
//  SNOOZE_SECS  300  ticks spent in SNOOZE before re-ringing (>=1; SNOOZE_EN only)
//  CNT_W        9    width of ring/snooze tick counter; must hold max(RING_SECS,SNOOZE_SECS)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  async reset, active-low (asserted when 0)
//  tick         in   1  1 Hz enable, one clock wide
//  button       in   1  raw pushbutton level, asynchronous
//  switches     in   9  [5:0] value, [6] field (0=min,1=hr), [8:7] mode req
//  disp_hours   out  5  hours shown, 0..23
//  disp_minutes out  6  minutes shown, 0..59
//  disp_seconds out  6  seconds shown, 0..59
//  blink        out  1  display blink request
//  buzzer_en    out  1  gate for buzzer tone generator
//  alarm_armed  out  1  alarm armed flag
// BEHAVIOUR
//  Reset: time 00:00:00, alarm 00:00, armed=0, state RUN, counter 0; all outputs 0.
//  Button: 2-flop sync + rising-edge detect -> 1-cycle press. Press acts 3 clocks after the edge.
//  Write value: hr field clamps >23 to 23; min field clamps >59 to 59.
//  Timekeeping on tick in every state except SET_TIME: sec 59->0 carries min; min 59->0 carries hr;
//   hr 23->0. All fields are registered; outputs update the cycle after tick.
//  Alarm match: on a RUN-state tick whose new time == alarm hh:mm:00 and armed=1 -> RINGING.
//   A match time passed while in SET_* is lost (no catch-up).
//  States (mode req = switches[8:7]):
//   RUN:       00/11 stay. In 11, press toggles armed. 01 -> SET_TIME, 10 -> SET_ALARM.
//              Match has priority over a mode change in the same cycle.
//   SET_TIME:  time frozen (ticks ignored); display = time; blink=1.
//              Press writes the selected field and clears seconds to 0.
//              Mode req !=01 -> RUN next cycle.
//   SET_ALARM: display = alarm hh:mm, seconds field 0; blink=1; time keeps running.
//              Press writes the alarm field. Mode req !=10 -> RUN.
//   RINGING:   buzzer_en=1; display = time; blink toggles each tick; mode req ignored.
//              Counter clears on entry, +1 per tick. At RING_SECS -> RUN.
//              Press -> RUN (press wins over the timeout tick in the same cycle).
//   SNOOZE:    (SNOOZE_EN only) buzzer_en=0, blink=0; counter clears on entry.
//              At SNOOZE_SECS -> RINGING. Press -> RUN (cancel).
//  Outputs in RUN: display = time; blink=0; buzzer_en=0.
//  Reset mid-ring or mid-set: immediate return to reset values; buzzer_en drops asynchronously.
//  Mode req changes are level-sensed every cycle; no debounce on the switches.
// CONFIGURATION
//  SNOOZE_ALARM_EN defined:
//   RINGING + press -> SNOOZE. Cancelling requires a press in SNOOZE or mode 11 + press in RUN
//   (disarm). Disarming while in SNOOZE is impossible; the press cancels SNOOZE instead.
//  SNOOZE_ALARM_EN undefined:
//   no SNOOZE state; RINGING + press -> RUN; SNOOZE_SECS unused.
// TESTING
//  1. Reset low, then high; apply 86400 ticks -> time wraps 23:59:59 -> 00:00:00; outputs 0 throughout.
//  2. Mode 01, sw[6]=1, value 30, press -> disp_hours=23, seconds=0.
//     Ticks while in SET_TIME leave the time unchanged.
//  3. Alarm 07:15, armed (mode 11 + press); time 07:14:59; tick -> buzzer_en=1 next cycle.
//     60 ticks later -> buzzer_en=0, state RUN.
//  4. Ringing; press and tick in the same cycle -> RUN, buzzer_en=0. No SNOOZE without the macro.
//  5. SNOOZE_ALARM_EN: ring, press -> buzzer 0; after 300 ticks -> buzzer 1; press in SNOOZE -> RUN.
//  6. Assert reset during RINGING -> buzzer_en=0 with no clock edge; time 00:00:00; armed=0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: mode and timekeeping controller for the alarm clock.
// Keeps time-of-day and alarm registers, and sequences run / set-time / set-alarm / ringing.
// Drives the display fields, the blink flag and the buzzer enable.
// Optional feature: define SNOOZE_ALARM_EN to add a SNOOZE state between ringing and dismissal.
module alarm_sequencer #(
   parameter int RING_SECS   = 60,   // ticks spent ringing before auto-dismiss
   parameter int SNOOZE_SECS = 300,  // ticks spent snoozing before re-ringing
   parameter int CNT_W       = 9     // must hold max(RING_SECS, SNOOZE_SECS)
) (
   input  logic       clock,
   input  logic       reset,         // asynchronous, active-low
   input  logic       tick,          // 1 Hz enable, one clock wide
   input  logic       button,        // raw pushbutton level, asynchronous
   input  logic [8:0] switches,      // [5:0] value, [6] field (1=hr), [8:7] mode request
   output logic [4:0] disp_hours,
   output logic [5:0] disp_minutes,
   output logic [5:0] disp_seconds,
   output logic       blink,
   output logic       buzzer_en,
   output logic       alarm_armed
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_TIME,
      ST_SET_ALARM,
      ST_RINGING
`ifdef SNOOZE_ALARM_EN
      , ST_SNOOZE
`endif
   } state_t;

   // The shared counter never has to count past the longer of the two periods.
   localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;

   state_t            state, state_nxt;
   logic [2:0]        btn_sync;
   logic              press;
   logic [4:0]        time_hr, alarm_hr, hr_inc, wr_hr;
   logic [5:0]        time_min, alarm_min, min_inc, wr_min;
   logic [5:0]        time_sec, sec_inc;
   logic [CNT_W-1:0]  cnt;
   logic              count_en;
   logic              match;
   logic [1:0]        mode_req;
   logic              field_hr;
   logic [5:0]        value;

   assign mode_req = switches[8:7];
   assign field_hr = switches[6];
   assign value    = switches[5:0];

   // Written values are clamped to the legal range of the selected field.
   assign wr_hr  = (value > 6'd23) ? 5'd23 : value[4:0];
   assign wr_min = (value > 6'd59) ? 6'd59 : value;

   // Two flops resynchronise the button; the third gives the rising edge, so a press acts 3 clocks in.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_sync <= '0;
      end else begin
         // NOTE: clocked state uses <= so every flop samples the pre-edge values of the others.
         btn_sync <= {btn_sync[1:0], button};
      end
   end

   assign press = btn_sync[1] & ~btn_sync[2];

   // Time-of-day one second ahead, with seconds/minutes/hours carries and midnight wrap.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      sec_inc = time_sec + 6'd1;
      min_inc = time_min;
      hr_inc  = time_hr;
      if (time_sec == 6'd59) begin
         sec_inc = '0;
         if (time_min == 6'd59) begin
            min_inc = '0;
            hr_inc  = (time_hr == 5'd23) ? 5'd0 : time_hr + 5'd1;
         end else begin
            min_inc = time_min + 6'd1;
         end
      end
   end

   // Alarm fires only on a RUN tick whose new time lands exactly on hh:mm:00.
   assign match = (state == ST_RUN) && tick && alarm_armed &&
                  (hr_inc == alarm_hr) && (min_inc == alarm_min) && (sec_inc == 6'd0);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Next-state decode and display/blink/buzzer selection.
   always_comb begin
      state_nxt    = state;
      disp_hours   = time_hr;
      disp_minutes = time_min;
      disp_seconds = time_sec;
      blink        = 1'b0;
      buzzer_en    = 1'b0;
      count_en     = 1'b0;
      case (state)
         ST_RUN: begin
            if (match)                  state_nxt = ST_RINGING;
            else if (mode_req == 2'b01) state_nxt = ST_SET_TIME;
            else if (mode_req == 2'b10) state_nxt = ST_SET_ALARM;
         end
         ST_SET_TIME: begin
            blink = 1'b1;
            if (mode_req != 2'b01) state_nxt = ST_RUN;
         end
         ST_SET_ALARM: begin
            disp_hours   = alarm_hr;
            disp_minutes = alarm_min;
            disp_seconds = '0;
            blink        = 1'b1;
            if (mode_req != 2'b10) state_nxt = ST_RUN;
         end
         ST_RINGING: begin
            buzzer_en = 1'b1;
            blink     = cnt[0];  // the tick counter's LSB toggles once per tick
            count_en  = 1'b1;
            if (press) begin
`ifdef SNOOZE_ALARM_EN
               state_nxt = ST_SNOOZE;
`else
               state_nxt = ST_RUN;
`endif
            end else if (tick && (cnt == CNT_W'(RING_SECS - 1))) begin
               state_nxt = ST_RUN;
            end
         end
`ifdef SNOOZE_ALARM_EN
         ST_SNOOZE: begin
            count_en = 1'b1;
            if (press)                                          state_nxt = ST_RUN;
            else if (tick && (cnt == CNT_W'(SNOOZE_SECS - 1))) state_nxt = ST_RINGING;
         end
`endif
         default: state_nxt = ST_RUN;
      endcase
   end

   // Tick counter: cleared on every state change, advanced per tick while ringing or snoozing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else if (count_en && tick && (cnt != CNT_W'(CNT_MAX))) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Time-of-day: frozen and writable in SET_TIME, otherwise advanced on every tick.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         time_hr  <= '0;
         time_min <= '0;
         time_sec <= '0;
      end else if (state == ST_SET_TIME) begin
         if (press) begin
            if (field_hr) time_hr  <= wr_hr;
            else          time_min <= wr_min;
            time_sec <= '0;
         end
      end else if (tick) begin
         time_hr  <= hr_inc;
         time_min <= min_inc;
         time_sec <= sec_inc;
      end
   end

   // Alarm time written in SET_ALARM; armed flag toggled by a press in RUN with mode 11.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alarm_hr    <= '0;
         alarm_min   <= '0;
         alarm_armed <= 1'b0;
      end else begin
         if ((state == ST_SET_ALARM) && press) begin
            if (field_hr) alarm_hr  <= wr_hr;
            else          alarm_min <= wr_min;
         end
         if ((state == ST_RUN) && (mode_req == 2'b11) && press && !match)
            alarm_armed <= ~alarm_armed;
      end
   end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scenario tasks drive the alarm sequencer, push the expected display view
// to a scoreboard queue, and pop/compare it once the DUT has taken the clock edge.
module tb_alarm_sequencer;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;

   logic       clock    = 1'b0;
   logic       reset    = 1'b1;
   logic       tick     = 1'b0;
   logic       button   = 1'b0;
   logic [8:0] switches = '0;
   logic [4:0] disp_hours;
   logic [5:0] disp_minutes;
   logic [5:0] disp_seconds;
   logic       blink;
   logic       buzzer_en;
   logic       alarm_armed;

   alarm_sequencer #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS),
      .CNT_W      (9)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .button      (button),
      .switches    (switches),
      .disp_hours  (disp_hours),
      .disp_minutes(disp_minutes),
      .disp_seconds(disp_seconds),
      .blink       (blink),
      .buzzer_en   (buzzer_en),
      .alarm_armed (alarm_armed)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       bl;
      logic       bz;
      logic       ar;
   } view_t;

   view_t sb[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model of time-of-day and the armed flag.
   int mh = 0, mm = 0, ms = 0;
   bit marmed = 1'b0;

   function automatic void model_tick();
      ms++;
      if (ms == 60) begin
         ms = 0;
         mm++;
         if (mm == 60) begin
            mm = 0;
            mh++;
            if (mh == 24) mh = 0;
         end
      end
   endfunction

   function automatic view_t view(input int h, input int m, input int s, input bit bl, input bit bz);
      view_t v;
      v.h  = 5'(h);
      v.m  = 6'(m);
      v.s  = 6'(s);
      v.bl = bl;
      v.bz = bz;
      v.ar = marmed;
      return v;
   endfunction

   function automatic view_t observed();
      view_t v;
      v.h  = disp_hours;
      v.m  = disp_minutes;
      v.s  = disp_seconds;
      v.bl = blink;
      v.bz = buzzer_en;
      v.ar = alarm_armed;
      return v;
   endfunction

   function automatic string fmt(input view_t v);
      return $sformatf("%0d:%0d:%0d blink=%0b buzz=%0b armed=%0b", v.h, v.m, v.s, v.bl, v.bz, v.ar);
   endfunction

   // Stimulus helpers; all start and end on a falling clock edge.
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic tick_once();
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
   endtask

   task automatic press();
      button = 1'b1;
      repeat (3) @(negedge clock);
      button = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Press whose synchronised pulse lands in the same clock as a tick.
   task automatic press_tick();
      button = 1'b1;
      repeat (2) @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick   = 1'b0;
      button = 1'b0;
   endtask

   task automatic set_mode(input logic [1:0] m);
      switches[8:7] = m;
      @(negedge clock);
   endtask

   task automatic write_field(input bit hr, input int v);
      switches[6]   = hr;
      switches[5:0] = 6'(v);
      press();
   endtask

   task automatic set_time(input int h, input int m);
      set_mode(2'b01);
      write_field(1'b1, h);
      write_field(1'b0, m);
      set_mode(2'b00);
      mh = (h > 23) ? 23 : h;
      mm = (m > 59) ? 59 : m;
      ms = 0;
   endtask

   task automatic test_reset();
      view_t e, g;
      #2 reset = 1'b0;
      #1;
      sb.push_back(view(0, 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_asserted: got %s expected %s", fmt(g), fmt(e)); end
      idle(2);
      reset = 1'b1;
      @(negedge clock);
      sb.push_back(view(0, 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_released: got %s expected %s", fmt(g), fmt(e)); end
   endtask

   task automatic test_timekeeping();
      view_t e, g;
      for (int i = 0; i < 3700; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL run_tick %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
   endtask

   task automatic test_set_time();
      view_t e, g;
      set_mode(2'b01);
      sb.push_back(view(mh, mm, ms, 1'b1, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL set_time_entry: got %s expected %s", fmt(g), fmt(e)); end
      write_field(1'b1, 30);
      mh = 23; ms = 0;
      sb.push_back(view(mh, mm, ms, 1'b1, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL hour_clamp: got %s expected %s", fmt(g), fmt(e)); end
      for (int i = 0; i < 5; i++) begin
         sb.push_back(view(mh, mm, ms, 1'b1, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL set_time_frozen %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
      write_field(1'b0, 62);
      mm = 59;
      sb.push_back(view(mh, mm, ms, 1'b1, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL minute_clamp: got %s expected %s", fmt(g), fmt(e)); end
      set_mode(2'b00);
      for (int i = 0; i < 60; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL wrap_tick %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
      sb.push_back(view(0, 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_midnight: got %s expected %s", fmt(g), fmt(e)); end
   endtask

   task automatic test_alarm_ring();
      view_t e, g;
      set_mode(2'b10);
      sb.push_back(view(0, 0, 0, 1'b1, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL set_alarm_entry: got %s expected %s", fmt(g), fmt(e)); end
      model_tick();
      sb.push_back(view(0, 0, 0, 1'b1, 1'b0));
      tick_once();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL set_alarm_tick: got %s expected %s", fmt(g), fmt(e)); end
      write_field(1'b1, 7);
      write_field(1'b0, 15);
      sb.push_back(view(7, 15, 0, 1'b1, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL alarm_written: got %s expected %s", fmt(g), fmt(e)); end
      set_mode(2'b11);
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL time_ran_in_set_alarm: got %s expected %s", fmt(g), fmt(e)); end
      press();
      marmed = 1'b1;
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL arm: got %s expected %s", fmt(g), fmt(e)); end
      set_mode(2'b00);
      set_time(7, 14);
      for (int i = 0; i < 59; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL pre_alarm %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
      model_tick();
      sb.push_back(view(7, 15, 0, 1'b0, 1'b1));
      tick_once();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL ring_start: got %s expected %s", fmt(g), fmt(e)); end
      for (int k = 1; k < RING_SECS; k++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, bit'(k % 2), 1'b1));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL ringing %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      end
      model_tick();
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      tick_once();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL ring_timeout: got %s expected %s", fmt(g), fmt(e)); end
   endtask

   task automatic test_ring_press();
      view_t e, g;
      set_time(7, 14);
      for (int i = 0; i < 60; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, bit'(i == 59)));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL reach_ring %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
      for (int k = 1; k <= 5; k++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, bit'(k % 2), 1'b1));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL ring_before_press %0d: got %s expected %s", k, fmt(g), fmt(e)); end
      end
      model_tick();
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      press_tick();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL press_with_tick: got %s expected %s", fmt(g), fmt(e)); end
      idle(3);
`ifdef SNOOZE_ALARM_EN
      for (int i = 1; i <= SNOOZE_SECS; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, bit'(i == SNOOZE_SECS)));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL snoozing %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
      press();
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL resnooze: got %s expected %s", fmt(g), fmt(e)); end
      press();
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL snooze_cancel: got %s expected %s", fmt(g), fmt(e)); end
      for (int i = 0; i < SNOOZE_SECS + 5; i++) begin
`else
      for (int i = 0; i < 5; i++) begin
`endif
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL after_dismiss %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
   endtask

   task automatic test_disarm();
      view_t e, g;
      set_mode(2'b11);
      press();
      marmed = 1'b0;
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL disarm: got %s expected %s", fmt(g), fmt(e)); end
      set_mode(2'b00);
      set_time(7, 14);
      for (int i = 0; i < 61; i++) begin
         model_tick();
         sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
         tick_once();
         e = sb.pop_front(); g = observed(); checks++;
         if (g !== e) begin errors++; $display("FAIL disarmed_no_ring %0d: got %s expected %s", i, fmt(g), fmt(e)); end
      end
   endtask

   task automatic test_reset_mid_ring();
      view_t e, g;
      set_mode(2'b11);
      press();
      marmed = 1'b1;
      sb.push_back(view(mh, mm, ms, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL rearm: got %s expected %s", fmt(g), fmt(e)); end
      set_mode(2'b00);
      set_time(7, 14);
      repeat (59) begin
         model_tick();
         tick_once();
      end
      switches[8:7] = 2'b01;
      model_tick();
      sb.push_back(view(7, 15, 0, 1'b0, 1'b1));
      tick_once();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL match_beats_mode: got %s expected %s", fmt(g), fmt(e)); end
      model_tick();
      sb.push_back(view(mh, mm, ms, 1'b1, 1'b1));
      tick_once();
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL ring_ignores_mode: got %s expected %s", fmt(g), fmt(e)); end
      #2 reset = 1'b0;
      #1;
      marmed = 1'b0;
      mh = 0; mm = 0; ms = 0;
      sb.push_back(view(0, 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL async_reset_ring: got %s expected %s", fmt(g), fmt(e)); end
      switches = '0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      sb.push_back(view(0, 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin errors++; $display("FAIL post_reset: got %s expected %s", fmt(g), fmt(e)); end
   endtask

   initial begin
      test_reset();
      test_timekeeping();
      test_set_time();
      test_alarm_ring();
      test_ring_press();
      test_disarm();
      test_reset_mid_ring();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
